// File: rtl/parity_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : parity_frame_tx                                              |
// | Description : Accepts a parallel word on a valid/ready handshake, shifts   |
// |               it out LSB first one bit per clock and appends a single      |
// |               even/odd parity bit. Frame = WIDTH data bits + 1 parity.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module parity_frame_tx #(
  parameter int WIDTH = 8,  // data bits per frame (>= 2)
  parameter int ODD   = 0   // 0 = even parity, 1 = odd parity
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic             ACC_INIT = 1'(ODD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             accept;

  // A new word may be taken while idle or during the parity cycle, so
  // back-to-back frames run with no gap; never while reset is asserted.
  assign in_ready = !rst && ((state == S_IDLE) || (state == S_PARITY));
  assign accept   = in_valid && in_ready;

  // Frame sequencer; outputs are registered so they describe the state entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      acc       <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_PARITY: begin
          if (accept) begin
            shreg     <= in_data;
            cnt       <= '0;
            acc       <= ACC_INIT;
            state     <= S_DATA;
            // Bit 0 of the new word is presented in the very next cycle.
            ser_out   <= in_data[0];
            ser_valid <= 1'b1;
            ser_last  <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state     <= S_IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
          end
        end
        S_DATA: begin
          acc       <= acc ^ shreg[0];
          shreg     <= shreg >> 1;
          ser_valid <= 1'b1;
          busy      <= 1'b1;
          if (cnt == CNT_LAST) begin
            // Last data bit leaving: fold it into the accumulator and emit parity.
            state    <= S_PARITY;
            ser_out  <= acc ^ shreg[0];
            ser_last <= 1'b1;
          end else begin
            // Next bit to present is the one about to become shreg[0].
            cnt      <= cnt + 1'b1;
            ser_out  <= shreg[1];
            ser_last <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_parity_frame_tx                                           |
// | Description : Directed bench for parity_frame_tx: three instances cover    |
// |               WIDTH=8 even, WIDTH=8 odd and WIDTH=3 even parity.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_parity_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: WIDTH=8 even
  logic       valid_a = 1'b0;
  logic [7:0] data_a  = '0;
  logic       ready_a, so_a, sv_a, sl_a, busy_a;
  // instance 1: WIDTH=8 odd
  logic       valid_b = 1'b0;
  logic [7:0] data_b  = '0;
  logic       ready_b, so_b, sv_b, sl_b, busy_b;
  // instance 2: WIDTH=3 even
  logic       valid_c = 1'b0;
  logic [2:0] data_c  = '0;
  logic       ready_c, so_c, sv_c, sl_c, busy_c;

  int vectors    = 0;
  int miscompares = 0;

  parity_frame_tx #(.WIDTH(8), .ODD(0)) u_even8 (
    .clk(clk), .rst(rst), .in_valid(valid_a), .in_data(data_a), .in_ready(ready_a),
    .ser_out(so_a), .ser_valid(sv_a), .ser_last(sl_a), .busy(busy_a));

  parity_frame_tx #(.WIDTH(8), .ODD(1)) u_odd8 (
    .clk(clk), .rst(rst), .in_valid(valid_b), .in_data(data_b), .in_ready(ready_b),
    .ser_out(so_b), .ser_valid(sv_b), .ser_last(sl_b), .busy(busy_b));

  parity_frame_tx #(.WIDTH(3), .ODD(0)) u_even3 (
    .clk(clk), .rst(rst), .in_valid(valid_c), .in_data(data_c), .in_ready(ready_c),
    .ser_out(so_c), .ser_valid(sv_c), .ser_last(sl_c), .busy(busy_c));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {busy, ser_last, ser_valid, ser_out} of the selected instance
  function automatic logic [3:0] get_out(input int which);
    case (which)
      0:       return {busy_a, sl_a, sv_a, so_a};
      1:       return {busy_b, sl_b, sv_b, so_b};
      default: return {busy_c, sl_c, sv_c, so_c};
    endcase
  endfunction

  function automatic logic get_ready(input int which);
    case (which)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  task automatic set_in(input int which, input logic v, input logic [7:0] word);
    case (which)
      0:       begin valid_a = v; data_a = word; end
      1:       begin valid_b = v; data_b = word; end
      default: begin valid_c = v; data_c = word[2:0]; end
    endcase
  endtask

  // Checks one serialized frame whose accept happened at the previous edge.
  task automatic check_bits(input int which, input logic [7:0] word, input int width,
                            input logic exp_p, input string tag);
    logic [3:0] o;
    for (int i = 0; i <= width; i++) begin
      @(negedge clk);
      o = get_out(which);
      check($sformatf("%s valid[%0d]", tag, i), {7'd0, o[1]}, 8'd1);
      check($sformatf("%s bit[%0d]", tag, i), {7'd0, o[0]},
            (i < width) ? {7'd0, word[i]} : {7'd0, exp_p});
      check($sformatf("%s last[%0d]", tag, i), {7'd0, o[2]}, (i == width) ? 8'd1 : 8'd0);
      check($sformatf("%s busy[%0d]", tag, i), {7'd0, o[3]}, 8'd1);
    end
  endtask

  // Full single frame: offer, accept, scramble in_data while busy, check, then idle.
  task automatic send_frame(input int which, input logic [7:0] word, input int width,
                            input logic exp_p, input string tag);
    logic [3:0] o;
    @(negedge clk);
    set_in(which, 1'b1, word);
    check({tag, " ready"}, {7'd0, get_ready(which)}, 8'd1);
    @(posedge clk);
    #1 set_in(which, 1'b0, ~word);
    check_bits(which, word, width, exp_p, tag);
    @(negedge clk);
    o = get_out(which);
    check({tag, " idle valid"}, {7'd0, o[1]}, 8'd0);
    check({tag, " idle busy"}, {7'd0, o[3]}, 8'd0);
  endtask

  logic [7:0] par3;
  logic [3:0] o;

  initial begin
    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", {7'd0, ready_a}, 8'd0);
    check("rst outs", {4'd0, get_out(0)}, 8'd0);
    check("rst outs odd", {4'd0, get_out(1)}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle ready", {7'd0, ready_a}, 8'd1);

    // ---- 1: 0xA5 even -> P=0 ----
    send_frame(0, 8'hA5, 8, 1'b0, "a5");
    // ---- 2: 0x07 even -> P=1; odd 0x00 -> 1, 0xFF -> 1 ----
    send_frame(0, 8'h07, 8, 1'b1, "07");
    send_frame(1, 8'h00, 8, 1'b1, "odd00");
    send_frame(1, 8'hFF, 8, 1'b1, "oddff");

    // ---- 3: WIDTH=3 exhaustive ----
    par3 = 8'b1001_0110;
    for (int v = 0; v < 8; v++)
      send_frame(2, 8'(v), 3, par3[v], $sformatf("w3_%0d", v));

    // ---- 4: back-to-back 0x01 then 0x03 with in_valid held ----
    @(negedge clk);
    set_in(0, 1'b1, 8'h01);
    @(posedge clk);
    #1 data_a = 8'h03;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      o = get_out(0);
      check($sformatf("b2b valid[%0d]", i), {7'd0, o[1]}, 8'd1);
      check($sformatf("b2b bit[%0d]", i), {7'd0, o[0]},
            (i == 0 || i == 8 || i == 9 || i == 10) ? 8'd1 : 8'd0);
      check($sformatf("b2b last[%0d]", i), {7'd0, o[2]},
            (i == 8 || i == 17) ? 8'd1 : 8'd0);
      if (i == 8) check("b2b ready parity", {7'd0, ready_a}, 8'd1);
      if (i == 9) valid_a = 1'b0;
    end
    @(negedge clk);
    check("b2b end valid", {7'd0, sv_a}, 8'd0);

    // ---- 5: reset during data bit 4 of 0xFF, with in_valid also high ----
    @(negedge clk);
    set_in(0, 1'b1, 8'hFF);
    @(posedge clk);
    #1 valid_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rstmid bit[%0d]", i), {7'd0, so_a}, 8'd1);
    end
    rst = 1'b1;
    valid_a = 1'b1;
    #1 check("rst wins ready", {7'd0, ready_a}, 8'd0);
    @(negedge clk);
    check("rstmid outs", {4'd0, get_out(0)}, 8'd0);
    rst = 1'b0;
    valid_a = 1'b0;
    send_frame(0, 8'h01, 8, 1'b1, "post_rst");

    // ---- 6: pulse ignored while busy; held word accepted in parity cycle ----
    @(negedge clk);
    set_in(0, 1'b1, 8'h81);
    @(posedge clk);
    #1 valid_a = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("busy bit[%0d]", i), {7'd0, so_a},
            (i == 0 || i == 7) ? 8'd1 : 8'd0);
      if (i == 2) begin
        check("busy ready", {7'd0, ready_a}, 8'd0);
        set_in(0, 1'b1, 8'h55);
      end
      if (i == 3) set_in(0, 1'b0, 8'h55);
      if (i == 5) set_in(0, 1'b1, 8'h0F);
      if (i == 8) check("held ready parity", {7'd0, ready_a}, 8'd1);
    end
    @(posedge clk);
    #1 valid_a = 1'b0;
    check_bits(0, 8'h0F, 8, 1'b0, "held0f");
    @(negedge clk);
    check("final idle", {4'd0, get_out(0)}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Bounded run: a stuck sequence still ends with a report.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
